// File: rtl/ifu_fetch.sv
// ifu_fetch
//   Instruction fetch stage feeding a single-cycle decode/execute core.
//   Owns the fetch PC and issues one word request at a time to instruction
//   memory. It captures the returned word and presents it to the core with a
//   valid/ready handshake. Redirects from execute override the sequential PC.
//   A redirect that arrives while a request is in flight marks that response
//   as stale, and the stale response is dropped.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   S_REQ  | drive request for pc (only if word aligned)
//   S_WAIT | one request outstanding, waiting for its response
//   S_OUT  | instruction held on instr_* until the core consumes it
//
// Ports
//   clk_i, rst_i              clock, synchronous active-high reset
//   redirect_valid_i/pc_i     PC change request from execute
//   mem_req_valid/ready/addr  request channel to instruction memory
//   mem_rsp_valid/data/err    response channel from instruction memory
//   instr_valid/ready         handshake towards the core
//   instr_o, instr_pc_o       instruction word and its PC
//   instr_fault_o             access fault or misaligned fetch PC
module ifu_fetch #(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = XLEN'(32'h8000_0000)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            mem_req_valid_o,
    input  logic            mem_req_ready_i,
    output logic [XLEN-1:0] mem_req_addr_o,
    input  logic            mem_rsp_valid_i,
    input  logic [XLEN-1:0] mem_rsp_data_i,
    input  logic            mem_rsp_err_i,
    output logic            instr_valid_o,
    input  logic            instr_ready_i,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] instr_pc_o,
    output logic            instr_fault_o
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            drop_q, drop_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] instr_pc_q, instr_pc_d;
    logic            fault_q, fault_d;
    logic            req_valid;
    logic            aligned;

    assign aligned = (pc_q[1:0] == 2'b00);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_REQ;
            pc_q       <= RESET_PC;
            drop_q     <= 1'b0;
            instr_q    <= '0;
            instr_pc_q <= RESET_PC;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            drop_q     <= drop_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            fault_q    <= fault_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        drop_d     = drop_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        fault_d    = fault_q;
        req_valid  = 1'b0;

        case (state_q)
            S_REQ: begin
                req_valid = aligned;
                if (redirect_valid_i) begin
                    pc_d = redirect_pc_i;
                    // Request already accepted for the old pc: its response
                    // must be thrown away when it returns.
                    if (req_valid && mem_req_ready_i) begin
                        state_d = S_WAIT;
                        drop_d  = 1'b1;
                    end
                end else if (!aligned) begin
                    // Misaligned pc never reaches memory; report it as a
                    // faulting instruction instead.
                    state_d    = S_OUT;
                    instr_d    = '0;
                    instr_pc_d = pc_q;
                    fault_d    = 1'b1;
                end else if (mem_req_ready_i) begin
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                if (redirect_valid_i) begin
                    pc_d = redirect_pc_i;
                    if (mem_rsp_valid_i) begin
                        state_d = S_REQ;
                        drop_d  = 1'b0;
                    end else begin
                        drop_d  = 1'b1;
                    end
                end else if (mem_rsp_valid_i) begin
                    if (drop_q) begin
                        state_d = S_REQ;
                        drop_d  = 1'b0;
                    end else begin
                        state_d    = S_OUT;
                        instr_d    = mem_rsp_err_i ? '0 : mem_rsp_data_i;
                        instr_pc_d = pc_q;
                        fault_d    = mem_rsp_err_i;
                    end
                end
            end

            S_OUT: begin
                // A redirect either follows a consumed instruction or squashes
                // the held one; in both cases fetch restarts at the new pc.
                if (redirect_valid_i) begin
                    pc_d    = redirect_pc_i;
                    state_d = S_REQ;
                end else if (instr_ready_i) begin
                    pc_d    = instr_pc_q + XLEN'(4);
                    state_d = S_REQ;
                end
            end

            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    assign mem_req_valid_o = req_valid;
    assign mem_req_addr_o  = pc_q;
    assign instr_valid_o   = (state_q == S_OUT);
    assign instr_o         = instr_q;
    assign instr_pc_o      = instr_pc_q;
    assign instr_fault_o   = fault_q;

endmodule

// File: tb/tb_ifu_fetch.sv
module tb_ifu_fetch;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        redirect_valid_i;
    logic [31:0] redirect_pc_i;
    logic        mem_req_valid_o;
    logic        mem_req_ready_i;
    logic [31:0] mem_req_addr_o;
    logic        mem_rsp_valid_i;
    logic [31:0] mem_rsp_data_i;
    logic        mem_rsp_err_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_fault_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    ifu_fetch #(.XLEN(32), .RESET_PC(32'h8000_0000)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .mem_req_valid_o  (mem_req_valid_o),
        .mem_req_ready_i  (mem_req_ready_i),
        .mem_req_addr_o   (mem_req_addr_o),
        .mem_rsp_valid_i  (mem_rsp_valid_i),
        .mem_rsp_data_i   (mem_rsp_data_i),
        .mem_rsp_err_i    (mem_rsp_err_i),
        .instr_valid_o    (instr_valid_o),
        .instr_ready_i    (instr_ready_i),
        .instr_o          (instr_o),
        .instr_pc_o       (instr_pc_o),
        .instr_fault_o    (instr_fault_o)
    );

    // Inputs applied during a cycle, and outputs expected during that same
    // cycle (all outputs are a function of registered state only).
    typedef struct {
        logic        rv;
        logic [31:0] rpc;
        logic        qrdy;
        logic        sv;
        logic [31:0] sd;
        logic        se;
        logic        irdy;
        logic        e_qv;
        logic [31:0] e_addr;
        logic        e_iv;
        logic [31:0] e_instr;
        logic [31:0] e_ipc;
        logic        e_flt;
    } vec_t;

    vec_t vq[$];

    task automatic addv(input logic rv, input logic [31:0] rpc, input logic qrdy,
                        input logic sv, input logic [31:0] sd, input logic se,
                        input logic irdy, input logic e_qv, input logic [31:0] e_addr,
                        input logic e_iv, input logic [31:0] e_instr,
                        input logic [31:0] e_ipc, input logic e_flt);
        vec_t v;
        v.rv = rv; v.rpc = rpc; v.qrdy = qrdy; v.sv = sv; v.sd = sd; v.se = se;
        v.irdy = irdy; v.e_qv = e_qv; v.e_addr = e_addr; v.e_iv = e_iv;
        v.e_instr = e_instr; v.e_ipc = e_ipc; v.e_flt = e_flt;
        vq.push_back(v);
    endtask

    task automatic drive(input logic rv, input logic [31:0] rpc, input logic qrdy,
                         input logic sv, input logic [31:0] sd, input logic se,
                         input logic irdy);
        redirect_valid_i = rv;
        redirect_pc_i    = rpc;
        mem_req_ready_i  = qrdy;
        mem_rsp_valid_i  = sv;
        mem_rsp_data_i   = sd;
        mem_rsp_err_i    = se;
        instr_ready_i    = irdy;
    endtask

    // Drive inputs for one cycle and advance to the next sampling point.
    task automatic cyc(input logic rv, input logic [31:0] rpc, input logic qrdy,
                       input logic sv, input logic [31:0] sd, input logic se,
                       input logic irdy);
        drive(rv, rpc, qrdy, sv, sd, se, irdy);
        @(negedge clk_i);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    initial begin
        // idx  rv rpc          qrdy sv sd            se irdy | qv addr         iv instr         ipc          flt
        addv(0, 32'h0,        1, 0, 32'h0,        0, 1,  1, 32'h80000000, 0, 32'h0,        32'h80000000, 0); // 0 reset state, accept
        addv(0, 32'h0,        0, 1, 32'h00000013, 0, 1,  0, 32'h80000000, 0, 32'h0,        32'h80000000, 0); // 1 wait, rsp
        addv(0, 32'h0,        0, 0, 32'h0,        0, 1,  0, 32'h80000000, 1, 32'h00000013, 32'h80000000, 0); // 2 out, consumed
        addv(0, 32'h0,        1, 0, 32'h0,        0, 1,  1, 32'h80000004, 0, 32'h00000013, 32'h80000000, 0); // 3 req +4
        addv(0, 32'h0,        0, 1, 32'h00000013, 0, 1,  0, 32'h80000004, 0, 32'h00000013, 32'h80000000, 0); // 4
        addv(0, 32'h0,        0, 0, 32'h0,        0, 1,  0, 32'h80000004, 1, 32'h00000013, 32'h80000004, 0); // 5
        addv(0, 32'h0,        0, 0, 32'h0,        0, 1,  1, 32'h80000008, 0, 32'h00000013, 32'h80000004, 0); // 6 mem not ready
        addv(0, 32'h0,        1, 0, 32'h0,        0, 1,  1, 32'h80000008, 0, 32'h00000013, 32'h80000004, 0); // 7 accept
        addv(1, 32'h80000100, 0, 0, 32'h0,        0, 1,  0, 32'h80000008, 0, 32'h00000013, 32'h80000004, 0); // 8 redirect in wait
        addv(0, 32'h0,        0, 0, 32'h0,        0, 1,  0, 32'h80000100, 0, 32'h00000013, 32'h80000004, 0); // 9
        addv(0, 32'h0,        0, 1, 32'hDEADBEEF, 0, 1,  0, 32'h80000100, 0, 32'h00000013, 32'h80000004, 0); // 10 stale rsp dropped
        addv(0, 32'h0,        1, 0, 32'h0,        0, 1,  1, 32'h80000100, 0, 32'h00000013, 32'h80000004, 0); // 11 req redirect pc
        addv(0, 32'h0,        0, 1, 32'h00000093, 0, 1,  0, 32'h80000100, 0, 32'h00000013, 32'h80000004, 0); // 12
        addv(1, 32'h80000200, 0, 0, 32'h0,        0, 1,  0, 32'h80000100, 1, 32'h00000093, 32'h80000100, 0); // 13 redirect+handshake
        addv(0, 32'h0,        1, 0, 32'h0,        0, 1,  1, 32'h80000200, 0, 32'h00000093, 32'h80000100, 0); // 14
        addv(0, 32'h0,        0, 1, 32'h00000113, 0, 1,  0, 32'h80000200, 0, 32'h00000093, 32'h80000100, 0); // 15
        addv(1, 32'h80000010, 0, 0, 32'h0,        0, 0,  0, 32'h80000200, 1, 32'h00000113, 32'h80000200, 0); // 16 squash held
        addv(0, 32'h0,        1, 0, 32'h0,        0, 1,  1, 32'h80000010, 0, 32'h00000113, 32'h80000200, 0); // 17
        addv(0, 32'h0,        0, 1, 32'h12345678, 1, 1,  0, 32'h80000010, 0, 32'h00000113, 32'h80000200, 0); // 18 err rsp
        addv(0, 32'h0,        0, 0, 32'h0,        0, 0,  0, 32'h80000010, 1, 32'h0,        32'h80000010, 1); // 19 fault shown
        addv(1, 32'h80000002, 0, 0, 32'h0,        0, 1,  0, 32'h80000010, 1, 32'h0,        32'h80000010, 1); // 20 to misaligned
        addv(0, 32'h0,        1, 0, 32'h0,        0, 1,  0, 32'h80000002, 0, 32'h0,        32'h80000010, 1); // 21 no request
        addv(0, 32'h0,        0, 0, 32'h0,        0, 0,  0, 32'h80000002, 1, 32'h0,        32'h80000002, 1); // 22 misaligned fault
        addv(1, 32'h80000020, 0, 0, 32'h0,        0, 1,  0, 32'h80000002, 1, 32'h0,        32'h80000002, 1); // 23
        addv(1, 32'h80000040, 1, 0, 32'h0,        0, 1,  1, 32'h80000020, 0, 32'h0,        32'h80000002, 1); // 24 redirect+accept
        addv(0, 32'h0,        0, 1, 32'hAAAAAAAA, 0, 1,  0, 32'h80000040, 0, 32'h0,        32'h80000002, 1); // 25 dropped
        addv(1, 32'h80000080, 0, 0, 32'h0,        0, 1,  1, 32'h80000040, 0, 32'h0,        32'h80000002, 1); // 26 redirect in req
        addv(1, 32'h80000084, 0, 0, 32'h0,        0, 1,  1, 32'h80000080, 0, 32'h0,        32'h80000002, 1); // 27 back-to-back
        addv(0, 32'h0,        1, 0, 32'h0,        0, 1,  1, 32'h80000084, 0, 32'h0,        32'h80000002, 1); // 28 last wins
        addv(1, 32'h800000C0, 0, 1, 32'hBBBBBBBB, 0, 1,  0, 32'h80000084, 0, 32'h0,        32'h80000002, 1); // 29 redirect+rsp
        addv(0, 32'h0,        0, 0, 32'h0,        0, 1,  1, 32'h800000C0, 0, 32'h0,        32'h80000002, 1); // 30

        rst_i = 1'b1;
        drive(0, 32'h0, 0, 0, 32'h0, 0, 0);
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].rv, vq[i].rpc, vq[i].qrdy, vq[i].sv, vq[i].sd, vq[i].se, vq[i].irdy);
            n_checks++;
            if ({mem_req_valid_o, mem_req_addr_o, instr_valid_o, instr_o, instr_pc_o, instr_fault_o} !==
                {vq[i].e_qv, vq[i].e_addr, vq[i].e_iv, vq[i].e_instr, vq[i].e_ipc, vq[i].e_flt}) begin
                n_fail++;
                $display("FAIL vec%0d: got qv=%b addr=%08h iv=%b instr=%08h pc=%08h flt=%b, expected qv=%b addr=%08h iv=%b instr=%08h pc=%08h flt=%b",
                         i, mem_req_valid_o, mem_req_addr_o, instr_valid_o, instr_o, instr_pc_o, instr_fault_o,
                         vq[i].e_qv, vq[i].e_addr, vq[i].e_iv, vq[i].e_instr, vq[i].e_ipc, vq[i].e_flt);
            end
            @(negedge clk_i);
        end

        // Core stall: held instruction stays put, no new request.
        cyc(0, 32'h0, 1, 0, 32'h0, 0, 1);
        cyc(0, 32'h0, 0, 1, 32'hCAFE0013, 0, 1);
        for (int k = 0; k < 5; k++) begin
            drive(0, 32'h0, 1, 0, 32'h0, 0, 0);
            chk("stall_iv",    32'(instr_valid_o),   32'h1);
            chk("stall_instr", instr_o,              32'hCAFE0013);
            chk("stall_pc",    instr_pc_o,           32'h800000C0);
            chk("stall_noreq", 32'(mem_req_valid_o), 32'h0);
            @(negedge clk_i);
        end
        cyc(0, 32'h0, 0, 0, 32'h0, 0, 1);
        chk("resume_qv",   32'(mem_req_valid_o), 32'h1);
        chk("resume_addr", mem_req_addr_o,       32'h800000C4);
        chk("resume_iv",   32'(instr_valid_o),   32'h0);

        // PC wrap at the top of the address space.
        cyc(1, 32'hFFFFFFFC, 0, 0, 32'h0, 0, 1);
        chk("wrap_addr0", mem_req_addr_o, 32'hFFFFFFFC);
        cyc(0, 32'h0, 1, 0, 32'h0, 0, 1);
        cyc(0, 32'h0, 0, 1, 32'h00000013, 0, 1);
        chk("wrap_ipc", instr_pc_o, 32'hFFFFFFFC);
        chk("wrap_iv",  32'(instr_valid_o), 32'h1);
        cyc(0, 32'h0, 0, 0, 32'h0, 0, 1);
        chk("wrap_qv",   32'(mem_req_valid_o), 32'h1);
        chk("wrap_addr", mem_req_addr_o,       32'h00000000);

        // Reset while a request is outstanding; the late response is ignored.
        cyc(0, 32'h0, 1, 0, 32'h0, 0, 1);
        chk("wait_noreq", 32'(mem_req_valid_o), 32'h0);
        rst_i = 1'b1;
        cyc(0, 32'h0, 0, 0, 32'h0, 0, 1);
        rst_i = 1'b0;
        drive(0, 32'h0, 0, 1, 32'hDEADBEEF, 0, 1);
        chk("rst_qv",    32'(mem_req_valid_o), 32'h1);
        chk("rst_addr",  mem_req_addr_o,       32'h80000000);
        chk("rst_iv",    32'(instr_valid_o),   32'h0);
        chk("rst_instr", instr_o,              32'h0);
        chk("rst_ipc",   instr_pc_o,           32'h80000000);
        @(negedge clk_i);
        chk("late_rsp_iv", 32'(instr_valid_o),   32'h0);
        chk("late_rsp_qv", 32'(mem_req_valid_o), 32'h1);
        cyc(0, 32'h0, 1, 0, 32'h0, 0, 1);
        cyc(0, 32'h0, 0, 1, 32'h00000013, 0, 1);
        chk("post_rst_iv",    32'(instr_valid_o), 32'h1);
        chk("post_rst_instr", instr_o,            32'h00000013);
        chk("post_rst_ipc",   instr_pc_o,         32'h80000000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
